// File: rtl/counter_pkg.sv
// Shared constants and helpers for the extended up/down counter family.
package counter_pkg;

  localparam int unsigned MODE_WRAP     = 0;
  localparam int unsigned MODE_SATURATE = 1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int unsigned CLAMP_W = 32;

  // Limit a requested load value to the counter's modulus-1.
  function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] value,
                                                    input logic [CLAMP_W-1:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle step strobe every PRESCALE enabled cycles.
module tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic step_c
);

  if (PRESCALE <= 1) begin : g_direct
    // Every enabled cycle steps, so no phase needs to be stored.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
    assign step_c = en && !clear;
  end else begin : g_div
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;

    assign step_c = en && !clear && (pre_q == LAST);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pre_q <= '0;
      end else if (clear) begin
        pre_q <= '0;
      end else if (en) begin
        pre_q <= step_c ? '0 : pre_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/updown_counter_ext.sv
// Parametrised up/down counter with modulus, wrap/saturate, prescaler, load, tc and sticky flags.
module updown_counter_ext
  import counter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned MAX_COUNT   = 2**DATA_WIDTH - 1,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned SATURATE    = MODE_WRAP,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  direction,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  clr_flags,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  udf
);

  localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MAX_COUNT);
  localparam logic [DATA_WIDTH-1:0] RST_V = DATA_WIDTH'(RESET_VALUE);
  localparam logic                  SAT   = (SATURATE == MODE_SATURATE);

  logic                  step_c;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  tc_q, tc_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clear  (load),
    .step_c (step_c)
  );

  // Next count and flags; boundary is checked before the arithmetic so no carry escapes.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q && !clr_flags;
    udf_d   = udf_q && !clr_flags;

    if (load) begin
      count_d = DATA_WIDTH'(clamp_load(CLAMP_W'(load_value), CLAMP_W'(MAX_COUNT)));
    end else if (step_c) begin
      if (direction == DIR_UP) begin
        if (count_q == MAX_V) begin
          count_d = SAT ? MAX_V : '0;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + DATA_WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = SAT ? '0 : MAX_V;
          tc_d    = 1'b1;
          udf_d   = 1'b1;
        end else begin
          count_d = count_q - DATA_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= RST_V;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_updown_counter_ext.sv
// Scoreboard bench: three counter configurations driven with directed, hand-computed vectors.
module tb_updown_counter_ext;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       direction = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       clr_flags = 1'b0;

  logic [3:0] count_w, count_s, count_p;
  logic       tc_w, tc_s, tc_p;
  logic       ovf_w, ovf_s, ovf_p;
  logic       udf_w, udf_s, udf_p;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int unsigned d;
    logic [3:0]  c;
    logic        t;
    logic        o;
    logic        u;
    string       nm;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  updown_counter_ext #(.DATA_WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(0), .RESET_VALUE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .direction(direction), .load(load),
    .load_value(load_value), .clr_flags(clr_flags),
    .count(count_w), .tc(tc_w), .ovf(ovf_w), .udf(udf_w)
  );

  updown_counter_ext #(.DATA_WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(1), .RESET_VALUE(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .direction(direction), .load(load),
    .load_value(load_value), .clr_flags(clr_flags),
    .count(count_s), .tc(tc_s), .ovf(ovf_s), .udf(udf_s)
  );

  updown_counter_ext #(.DATA_WIDTH(4), .MAX_COUNT(9), .PRESCALE(3), .SATURATE(0), .RESET_VALUE(0)) dut_pre (
    .clk(clk), .rst_n(rst_n), .en(en), .direction(direction), .load(load),
    .load_value(load_value), .clr_flags(clr_flags),
    .count(count_p), .tc(tc_p), .ovf(ovf_p), .udf(udf_p)
  );

  // Drive one cycle of inputs and queue the state expected after the next rising edge.
  task automatic cyc(input int unsigned d, input logic r, input logic e, input logic dir,
                     input logic ld, input logic [3:0] lv, input logic clr,
                     input logic [3:0] c, input logic t, input logic o, input logic u,
                     input string nm);
    exp_t x;
    @(negedge clk);
    rst_n      = r;
    en         = e;
    direction  = dir;
    load       = ld;
    load_value = lv;
    clr_flags  = clr;
    x.d = d; x.c = c; x.t = t; x.o = o; x.u = u; x.nm = nm;
    q.push_back(x);
  endtask

  // Monitor: one expectation retires per rising edge, sampled just after it.
  always @(posedge clk) begin
    exp_t       x;
    logic [3:0] ac;
    logic       at, ao, au;
    #1;
    if (q.size() != 0) begin
      x = q.pop_front();
      case (x.d)
        0:       begin ac = count_w; at = tc_w; ao = ovf_w; au = udf_w; end
        1:       begin ac = count_s; at = tc_s; ao = ovf_s; au = udf_s; end
        default: begin ac = count_p; at = tc_p; ao = ovf_p; au = udf_p; end
      endcase
      checks++;
      if ({ac, at, ao, au} !== {x.c, x.t, x.o, x.u}) begin
        errors++;
        $display("FAIL %s dut%0d: got count=%0d tc=%b ovf=%b udf=%b, want count=%0d tc=%b ovf=%b udf=%b",
                 x.nm, x.d, ac, at, ao, au, x.c, x.t, x.o, x.u);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Wrap mode: reset hold with en/up asserted, then 12 up steps through the wrap.
    for (int i = 0; i < 25; i++) cyc(0, 0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, "reset_hold");
    for (int i = 1; i <= 9; i++) cyc(0, 1, 1, 1, 0, 4'd0, 0, 4'(i), 0, 0, 0, "up_step");
    cyc(0, 1, 1, 1, 0, 4'd0, 0, 4'd0, 1, 1, 0, "up_wrap_tc");
    cyc(0, 1, 1, 1, 0, 4'd0, 0, 4'd1, 0, 1, 0, "up_after_wrap");
    cyc(0, 1, 1, 1, 0, 4'd0, 0, 4'd2, 0, 1, 0, "up_after_wrap2");
    cyc(0, 1, 0, 1, 0, 4'd0, 0, 4'd2, 0, 1, 0, "en_low_hold");
    cyc(0, 1, 0, 1, 0, 4'd0, 0, 4'd2, 0, 1, 0, "en_low_hold2");

    // Down wrap, flag clear, and set-wins when clear coincides with an underflow.
    cyc(0, 1, 0, 1, 1, 4'd1, 0, 4'd1, 0, 1, 0, "load_1");
    cyc(0, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0, "down_to_0");
    cyc(0, 1, 1, 0, 0, 4'd0, 0, 4'd9, 1, 1, 1, "down_wrap_tc");
    cyc(0, 1, 1, 0, 0, 4'd0, 0, 4'd8, 0, 1, 1, "down_8");
    cyc(0, 1, 0, 0, 0, 4'd0, 1, 4'd8, 0, 0, 0, "clr_flags");
    cyc(0, 1, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0, 0, "load_0");
    cyc(0, 1, 1, 0, 0, 4'd0, 1, 4'd9, 1, 0, 1, "clr_vs_udf_set_wins");
    cyc(0, 1, 0, 0, 0, 4'd0, 0, 4'd9, 0, 0, 1, "udf_sticky");

    // Load beats step and is clamped; reset beats load.
    cyc(0, 1, 1, 1, 1, 4'd15, 0, 4'd9, 0, 0, 1, "load_clamp_no_step");
    cyc(0, 0, 1, 1, 1, 4'd5, 0, 4'd0, 0, 0, 0, "reset_over_load");

    // Saturate mode: hold at 9 with a tc per saturated step, then same at 0.
    cyc(1, 0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, "sat_reset");
    cyc(1, 1, 0, 1, 1, 4'd8, 0, 4'd8, 0, 0, 0, "sat_load_8");
    cyc(1, 1, 1, 1, 0, 4'd0, 0, 4'd9, 0, 0, 0, "sat_up_1");
    cyc(1, 1, 1, 1, 0, 4'd0, 0, 4'd9, 1, 1, 0, "sat_up_2");
    cyc(1, 1, 1, 1, 0, 4'd0, 0, 4'd9, 1, 1, 0, "sat_up_3");
    cyc(1, 1, 1, 1, 0, 4'd0, 0, 4'd9, 1, 1, 0, "sat_up_4");
    cyc(1, 1, 0, 0, 1, 4'd1, 0, 4'd1, 0, 1, 0, "sat_load_1");
    cyc(1, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0, "sat_dn_1");
    cyc(1, 1, 1, 0, 0, 4'd0, 0, 4'd0, 1, 1, 1, "sat_dn_2");
    cyc(1, 1, 1, 0, 0, 4'd0, 0, 4'd0, 1, 1, 1, "sat_dn_3");
    cyc(1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 1, "sat_idle");

    // Prescale by 3: phase survives en=0, load restarts the period.
    cyc(2, 0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, "pre_reset");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, "pre_ph1");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, "pre_ph2");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd1, 0, 0, 0, "pre_step1");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd1, 0, 0, 0, "pre_ph1b");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd1, 0, 0, 0, "pre_ph2b");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd2, 0, 0, 0, "pre_step2");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd2, 0, 0, 0, "pre_ph1c");
    for (int i = 0; i < 5; i++) cyc(2, 1, 0, 1, 0, 4'd0, 0, 4'd2, 0, 0, 0, "pre_en_low");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd2, 0, 0, 0, "pre_resume_ph2");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd3, 0, 0, 0, "pre_resume_step");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd3, 0, 0, 0, "pre_ph1d");
    cyc(2, 1, 1, 1, 1, 4'd7, 0, 4'd7, 0, 0, 0, "pre_load_7");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd7, 0, 0, 0, "pre_after_load1");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd7, 0, 0, 0, "pre_after_load2");
    cyc(2, 1, 1, 1, 0, 4'd0, 0, 4'd8, 0, 0, 0, "pre_after_load_step");

    // Let the monitor retire the last expectation, bounded.
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
